// File: rtl/matmul_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : matmul_ram_loader
// Purpose  : Streams matrix A then matrix B (row-major, DEPTH elements each)
//            into two write-only RAM ports. It then launches
//            matrix_multiplication, waits for its done flag or a RUN timeout,
//            and acknowledges with a one-cycle clear_done pulse.
// Revision : 1.0  initial release
//
// Ports
//   clk, reset           sole clock; synchronous active-high reset
//   load_req             starts a sequence (honoured only in IDLE)
//   go                   launches compute from WAIT_GO (manual mode)
//   s_valid/s_data       element stream in; s_ready high in LOAD_A/LOAD_B
//   a_we/a_addr/a_data   matrix_A RAM write port (registered)
//   b_we/b_addr/b_data   matrix_B RAM write port (registered)
//   start                high for the whole of RUN
//   clear_done           one-cycle acknowledge in CLEAR
//   done_mat_mul         compute-complete flag (rising edge ends RUN)
//   busy                 high in every state except IDLE
//   timeout_err          sticky RUN-timeout flag
//
// Configuration macro
//   LOADER_AUTO_START_EN  WAIT_GO lasts one cycle and go is ignored.
// ============================================================================
module matmul_ram_loader #(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 5,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              go,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  output logic              a_we,
  output logic [AWIDTH-1:0] a_addr,
  output logic [DWIDTH-1:0] a_data,
  output logic              b_we,
  output logic [AWIDTH-1:0] b_addr,
  output logic [DWIDTH-1:0] b_data,
  output logic              start,
  output logic              clear_done,
  input  logic              done_mat_mul,
  output logic              busy,
  output logic              timeout_err
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]     LAST_RUN = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    WAIT_GO = 3'd3,
    RUN     = 3'd4,
    CLEAR   = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [AWIDTH-1:0] idx;
  logic [CW-1:0]     run_cnt;
  logic              done_prev;
  logic              accept;
  logic              last_beat;
  logic              done_rise;
  logic              run_expired;

  assign s_ready   = (state == LOAD_A) || (state == LOAD_B);
  assign accept    = s_valid && s_ready;
  assign last_beat = accept && (idx == LAST_IDX);
  // done_prev is sampled in every state, so a flag already high when RUN is
  // entered does not look like a rising edge.
  assign done_rise = done_mat_mul && !done_prev;
  // run_cnt holds the number of RUN cycles already completed; the cycle in
  // which it equals TIMEOUT-1 is the TIMEOUT-th RUN cycle.
  assign run_expired = (state == RUN) && (run_cnt == LAST_RUN);

`ifdef LOADER_AUTO_START_EN
  logic unused_go;
  assign unused_go = go;
`endif

  always_comb begin
    state_next = state;
    start      = 1'b0;
    clear_done = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load_req) state_next = LOAD_A;
      end
      LOAD_A:  if (last_beat) state_next = LOAD_B;
      LOAD_B:  if (last_beat) state_next = WAIT_GO;
      WAIT_GO: begin
`ifdef LOADER_AUTO_START_EN
        state_next = RUN;
`else
        if (go) state_next = RUN;
`endif
      end
      RUN: begin
        start = 1'b1;
        if (done_rise || run_expired) state_next = CLEAR;
      end
      CLEAR: begin
        clear_done = 1'b1;
        state_next = IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      run_cnt     <= '0;
      done_prev   <= 1'b0;
      timeout_err <= 1'b0;
      a_we        <= 1'b0;
      a_addr      <= '0;
      a_data      <= '0;
      b_we        <= 1'b0;
      b_addr      <= '0;
      b_data      <= '0;
    end else begin
      state     <= state_next;
      done_prev <= done_mat_mul;

      // DEPTH is a power of two, so the index wraps to 0 by itself when the
      // last element of A is accepted.
      if (accept) idx <= idx + 1'b1;

      // Held at 0 outside RUN so it is cleared on RUN entry.
      run_cnt <= (state == RUN) ? run_cnt + 1'b1 : '0;

      // Address and data stay 0 whenever the matching strobe is low.
      a_we   <= accept && (state == LOAD_A);
      a_addr <= (accept && (state == LOAD_A)) ? idx    : '0;
      a_data <= (accept && (state == LOAD_A)) ? s_data : '0;
      b_we   <= accept && (state == LOAD_B);
      b_addr <= (accept && (state == LOAD_B)) ? idx    : '0;
      b_data <= (accept && (state == LOAD_B)) ? s_data : '0;

      // A done edge in the same cycle as expiry takes priority: no error.
      if ((state == IDLE) && load_req)     timeout_err <= 1'b0;
      else if (run_expired && !done_rise)  timeout_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_ram_loader
// Purpose  : Directed self-checking bench. Two loaders share the stream and
//            control inputs: "m" uses the default TIMEOUT and "t" uses
//            TIMEOUT=16, each with its own done_mat_mul input.
// Revision : 1.0  initial release
// ============================================================================
module tb_matmul_ram_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_req = 1'b0;
  logic       go = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       done_m = 1'b0;
  logic       done_t = 1'b0;

  logic       m_s_ready, m_a_we, m_b_we, m_start, m_clear_done, m_busy, m_timeout_err;
  logic [4:0] m_a_addr, m_b_addr;
  logic [7:0] m_a_data, m_b_data;
  logic       t_s_ready, t_a_we, t_b_we, t_start, t_clear_done, t_busy, t_timeout_err;
  logic [4:0] t_a_addr, t_b_addr;
  logic [7:0] t_a_data, t_b_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matmul_ram_loader u_dut_m (
    .clk(clk), .reset(reset), .load_req(load_req), .go(go),
    .s_valid(s_valid), .s_data(s_data), .s_ready(m_s_ready),
    .a_we(m_a_we), .a_addr(m_a_addr), .a_data(m_a_data),
    .b_we(m_b_we), .b_addr(m_b_addr), .b_data(m_b_data),
    .start(m_start), .clear_done(m_clear_done), .done_mat_mul(done_m),
    .busy(m_busy), .timeout_err(m_timeout_err)
  );

  matmul_ram_loader #(.TIMEOUT(16)) u_dut_t (
    .clk(clk), .reset(reset), .load_req(load_req), .go(go),
    .s_valid(s_valid), .s_data(s_data), .s_ready(t_s_ready),
    .a_we(t_a_we), .a_addr(t_a_addr), .a_data(t_a_data),
    .b_we(t_b_we), .b_addr(t_b_addr), .b_data(t_b_data),
    .start(t_start), .clear_done(t_clear_done), .done_mat_mul(done_t),
    .busy(t_busy), .timeout_err(t_timeout_err)
  );

  // Packed views: write ports and control/status outputs.
  logic [31:0] wr_m, wr_t, st_m, st_t;
  assign wr_m = {4'b0, m_a_we, m_a_addr, m_a_data, m_b_we, m_b_addr, m_b_data};
  assign wr_t = {4'b0, t_a_we, t_a_addr, t_a_data, t_b_we, t_b_addr, t_b_data};
  assign st_m = {27'b0, m_s_ready, m_start, m_clear_done, m_busy, m_timeout_err};
  assign st_t = {27'b0, t_s_ready, t_start, t_clear_done, t_busy, t_timeout_err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] wpack(input logic aw, input logic bw,
                                        input logic [4:0] ad, input logic [7:0] d);
    return {4'b0, aw, aw ? ad : 5'd0, aw ? d : 8'd0, bw, bw ? ad : 5'd0, bw ? d : 8'd0};
  endfunction

  function automatic logic [31:0] spack(input logic rdy, input logic st, input logic cd,
                                        input logic bz, input logic er);
    return {27'b0, rdy, st, cd, bz, er};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("enter_load_a", st_m, spack(1, 0, 0, 1, 0));
  endtask

  // Beats first..first+n-1 of the A-then-B stream; stall inserts one idle
  // cycle after every accepted beat.
  task automatic load_beats(input int first, input int n, input bit stall);
    for (int i = 0; i < n; i++) begin
      int b;
      logic [7:0] d;
      b = first + i;
      d = stall ? (8'(b) ^ 8'h5A) : ((b < 32) ? 8'h02 : 8'h01);
      s_valid = 1'b1;
      s_data  = d;
      step();
      chk("wr_m", wr_m, wpack(b < 32, b >= 32, 5'(b), d));
      chk("wr_t", wr_t, wpack(b < 32, b >= 32, 5'(b), d));
      chk("rdy_m", st_m, spack(b != 63, 0, 0, 1, 0));
      if (stall) begin
        s_valid = 1'b0;
        s_data  = 8'hFF;
        step();
        chk("stall_wr", wr_m, 32'h0);
      end
    end
    s_valid = 1'b0;
  endtask

  // Called at the negedge right after the last B beat; returns at the
  // negedge of the first RUN cycle.
  task automatic wait_go_to_run();
`ifdef LOADER_AUTO_START_EN
    chk("wait_go", st_m, spack(0, 0, 0, 1, 0));
    step();
`else
    for (int i = 0; i < 3; i++) begin
      chk("wait_go_hold", st_m, spack(0, 0, 0, 1, 0));
      step();
    end
    go = 1'b1;
    step();
    go = 1'b0;
`endif
  endtask

  initial begin
    // Reset state
    step();
    step();
    chk("rst_wr_m", wr_m, 32'h0);
    chk("rst_st_m", st_m, 32'h0);
    chk("rst_wr_t", wr_t, 32'h0);
    chk("rst_st_t", st_t, 32'h0);
    reset = 1'b0;
    step();
    chk("idle_hold", st_m, 32'h0);

    // 64 back-to-back beats: A=02 x32 then B=01 x32
    pulse_load_req();
    load_beats(0, 64, 1'b0);
    wait_go_to_run();

    // m: done rises in RUN cycle 50; t: times out after 16 RUN cycles
    for (int c = 1; c <= 56; c++) begin
      chk("run50_m", st_m, spack(0, c <= 50, c == 51, c <= 51, 0));
      chk("tmo_t", st_t, spack(0, c <= 16, c == 17, c <= 17, c >= 17));
      if (c == 50) done_m = 1'b1;
      step();
    end

    // Next load_req clears timeout_err; stalled stream 1,0,1,0...
    pulse_load_req();
    chk("terr_clr", {31'b0, t_timeout_err}, 32'h0);
    load_beats(0, 64, 1'b1);
    wait_go_to_run();

    // m: done already high on entry is ignored, later edge ends RUN.
    // t: done edge in the same cycle as expiry wins, no error.
    for (int c = 1; c <= 28; c++) begin
      chk("run_m", st_m, spack(0, c <= 25, c == 26, c <= 26, 0));
      chk("race_t", st_t, spack(0, c <= 16, c == 17, c <= 17, 0));
      if (c == 16) done_t = 1'b1;
      if (c == 20) done_m = 1'b0;
      if (c == 25) done_m = 1'b1;
      step();
    end
    done_m = 1'b0;
    done_t = 1'b0;

    // Reset at beat 40: pending write dropped, everything back to 0
    pulse_load_req();
    load_beats(0, 40, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'h01;
    reset   = 1'b1;
    step();
    chk("mid_rst_wr_m", wr_m, 32'h0);
    chk("mid_rst_st_m", st_m, 32'h0);
    chk("mid_rst_wr_t", wr_t, 32'h0);
    chk("mid_rst_st_t", st_t, 32'h0);
    reset   = 1'b0;
    s_valid = 1'b0;
    step();
    chk("post_rst_idle", st_m, 32'h0);
    pulse_load_req();
    load_beats(0, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_ram_loader.md
MATMUL_RAM_LOADER -- requirements
Module: matmul_ram_loader

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, element width in bits.
REQ-002 SHALL have parameter AWIDTH, default 5, RAM address width; DEPTH = 2**AWIDTH (32).
REQ-003 SHALL have parameter TIMEOUT, default 4096, max cycles in RUN before error.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_req  input  1  one-cycle request to begin a load/compute sequence.
REQ-007 go  input  1  launch compute after load (manual mode only).
REQ-008 s_valid  input  1  element-stream valid.
REQ-009 s_data  input  DWIDTH  element value; A row-major first, then B.
REQ-010 s_ready  output  1  loader accepts s_data this cycle.
REQ-011 a_we / b_we  output  1 each  write strobe for matrix_A / matrix_B RAM.
REQ-012 a_addr / b_addr  output  AWIDTH each  RAM write address.
REQ-013 a_data / b_data  output  DWIDTH each  RAM write data.
REQ-014 start  output  1  start request to matrix_multiplication.
REQ-015 clear_done  output  1  one-cycle done acknowledge.
REQ-016 done_mat_mul  input  1  compute-complete flag from matrix_multiplication.
REQ-017 busy  output  1  high in any state except IDLE.
REQ-018 timeout_err  output  1  sticky; set when RUN exceeds TIMEOUT cycles.

Function
REQ-019 SHALL implement states IDLE, LOAD_A, LOAD_B, WAIT_GO, RUN, CLEAR.
REQ-020 IDLE -> LOAD_A on load_req=1; load_req outside IDLE SHALL be ignored.
REQ-021 s_ready SHALL be 1 exactly in LOAD_A and LOAD_B; a beat is accepted when s_valid&&s_ready.
REQ-022 Each accepted beat SHALL produce a registered write in the next cycle: we=1, addr=element index, data=s_data; one-cycle latency, no gaps when s_valid held high.
REQ-023 Element index SHALL count 0..DEPTH-1 per matrix; accepting index DEPTH-1 in LOAD_A moves to LOAD_B with index wrapped to 0.
REQ-024 Accepting index DEPTH-1 in LOAD_B SHALL move to WAIT_GO.
REQ-025 s_valid=0 during LOAD_* SHALL stall with index and state held; no write issued.
REQ-026 a_we and b_we SHALL never be 1 in the same cycle; addr/data SHALL be 0 when the corresponding we=0.
REQ-027 WAIT_GO -> RUN on go=1 (manual mode); start SHALL be 1 for the whole of RUN and 0 elsewhere.
REQ-028 RUN -> CLEAR on rising edge of done_mat_mul (registered previous value 0, current 1); done already high on RUN entry SHALL NOT count.
REQ-029 CLEAR SHALL last exactly one cycle with clear_done=1 and start=0, then return to IDLE.
REQ-030 A RUN cycle counter SHALL clear on RUN entry; reaching TIMEOUT SHALL set timeout_err and force CLEAR.
REQ-031 timeout_err SHALL clear only on reset or on the next load_req accepted in IDLE.
REQ-032 done_mat_mul rise and counter reaching TIMEOUT in the same cycle: done wins, timeout_err not set.

Reset
REQ-033 reset=1 at a clock edge SHALL force IDLE, index=0, counter=0 and all outputs 0, including mid-load and mid-RUN.
REQ-034 Writes pending in the cycle reset is sampled SHALL be dropped (we=0 next cycle).

Configuration
REQ-035 Macro LOADER_AUTO_START_EN: when defined, WAIT_GO SHALL last one cycle and proceed to RUN regardless of go; go port remains but is ignored.
REQ-036 Without LOADER_AUTO_START_EN, WAIT_GO SHALL hold indefinitely until go=1.

Verification
REQ-037 reset, load_req, 64 back-to-back beats (A=8'h02 x32, B=8'h01 x32) -> a_we at addr 0..31 data 02, then b_we at 0..31 data 01, 64 consecutive write cycles.
REQ-038 s_valid toggled 1,0,1,0 during load -> writes only on accepted beats, addresses contiguous, no skipped index.
REQ-039 after load, go=1; done_mat_mul rises 50 cycles later -> start high 50 cycles, then clear_done high 1 cycle, busy falls next cycle.
REQ-040 TIMEOUT=16, done_mat_mul held 0 -> timeout_err=1 after 16 RUN cycles, clear_done pulse, return to IDLE; next load_req clears timeout_err.
REQ-041 reset asserted at beat 40 -> IDLE, all outputs 0; fresh load restarts at a_addr 0.
REQ-042 with LOADER_AUTO_START_EN, go held 0 -> start rises two cycles after last B beat accepted.
